// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor
// Passive checker for the SDRAM power-up sequence. It decodes the command bus
// driven by the init controller and tracks the sequence: power-up wait, PRECHARGE ALL,
// tRP, AR_NUM x AUTO REFRESH with tRFC, MODE REGISTER SET, then tMRD.
// It reports the first violation, or ready once the sequence completes legally.
// Every output comes from a register.
module sdram_init_monitor #(
  parameter int T_POWER = 20000,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 7,
  parameter int T_MRD   = 3,
  parameter int AR_NUM  = 8
) (
  input  logic        mon_clk,
  input  logic        mon_rst_n,
  input  logic [3:0]  mon_cmd,
  input  logic [1:0]  mon_bank,
  input  logic [12:0] mon_addr,
  output logic        mon_ready,
  output logic        mon_err,
  output logic [2:0]  mon_err_code,
  output logic [12:0] mon_mode,
  output logic [3:0]  mon_ar_cnt
);

  // Counter widths. The gap counter has one spare count beyond the largest
  // timing limit, so a saturated gap still compares as "long enough".
  localparam int PWR_W   = (T_POWER < 1) ? 1 : $clog2(T_POWER + 1);
  localparam int GAP_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                          : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
  localparam int GAP_W   = $clog2(GAP_MAX + 2);

  localparam logic [PWR_W-1:0] L_PWR  = PWR_W'(T_POWER);
  localparam logic [GAP_W-1:0] L_RP   = GAP_W'(T_RP);
  localparam logic [GAP_W-1:0] L_RFC  = GAP_W'(T_RFC);
  localparam logic [GAP_W-1:0] L_MRD  = GAP_W'(T_MRD);
  localparam logic [GAP_W-1:0] L_ONE  = GAP_W'(1);
  localparam logic [3:0]       L_AR   = 4'(AR_NUM);

  // Violation codes
  localparam logic [2:0] E_PWR  = 3'd1;
  localparam logic [2:0] E_SEQ  = 3'd2;
  localparam logic [2:0] E_TRP  = 3'd3;
  localparam logic [2:0] E_TRFC = 3'd4;
  localparam logic [2:0] E_TMRD = 3'd5;
  localparam logic [2:0] E_MODE = 3'd6;
  localparam logic [2:0] E_PREB = 3'd7;

  typedef enum logic [2:0] {
    M_PWR,
    M_PRE,
    M_TRP,
    M_TRFC,
    M_TMRD,
    M_DONE,
    M_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  state_t            w_eff_state;
  logic [PWR_W-1:0]  r_pwr_cnt;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  w_gap_next;
  logic              r_ready;
  logic              r_err;
  logic [2:0]        r_err_code;
  logic [12:0]       r_mode;
  logic [3:0]        r_ar_cnt;

  logic              w_is_nop;
  logic              w_is_pre;
  logic              w_is_ar;
  logic              w_is_mrs;
  logic              w_mode_bad;
  logic              w_pwr_done;
  logic              w_timing_bad;
  logic [2:0]        w_timing_code;
  logic              w_err_set;
  logic [2:0]        w_err_code;
  logic              w_ar_inc;
  logic              w_mode_load;
  logic              w_ready_set;

  // Command decode: deselect and the explicit NOP encoding are both no-ops.
  assign w_is_nop = mon_cmd[3] | (mon_cmd == 4'b0111);
  assign w_is_pre = (mon_cmd == 4'b0010);
  assign w_is_ar  = (mon_cmd == 4'b0001);
  assign w_is_mrs = (mon_cmd == 4'b0000);

  // Legal mode word: bank 0, reserved bits clear, CAS latency 2 or 3,
  // burst length 1/2/4/8/full page, standard operating mode.
  assign w_mode_bad = (mon_bank != 2'b00)
                    | (mon_addr[12:10] != 3'b000)
                    | ~((mon_addr[6:4] == 3'd2) | (mon_addr[6:4] == 3'd3))
                    | ~((mon_addr[2:0] == 3'd0) | (mon_addr[2:0] == 3'd1) |
                        (mon_addr[2:0] == 3'd2) | (mon_addr[2:0] == 3'd3) |
                        (mon_addr[2:0] == 3'd7))
                    | (mon_addr[8:7] != 2'b00);

  assign w_pwr_done = (r_pwr_cnt >= L_PWR);

  // Gap seen by the next cycle: restarts at 1 after any real command.
  assign w_gap_next = !w_is_nop ? L_ONE :
                      ((r_gap == {GAP_W{1'b1}}) ? r_gap : r_gap + L_ONE);

  // Next-state and event decode for the init sequence checker.
  always_comb begin
    w_state_next  = r_state;
    w_eff_state   = r_state;
    w_timing_bad  = 1'b0;
    w_timing_code = 3'd0;
    w_err_set     = 1'b0;
    w_err_code    = 3'd0;
    w_ar_inc      = 1'b0;
    w_mode_load   = 1'b0;
    w_ready_set   = 1'b0;

    // Once the power-up wait has elapsed, M_PWR behaves exactly like M_PRE.
    if (r_state == M_PWR && w_pwr_done) begin
      w_eff_state  = M_PRE;
      w_state_next = M_PRE;
    end

    case (w_eff_state)
      M_TRP:   begin w_timing_bad = (r_gap < L_RP);  w_timing_code = E_TRP;  end
      M_TRFC:  begin w_timing_bad = (r_gap < L_RFC); w_timing_code = E_TRFC; end
      M_TMRD:  begin w_timing_bad = (r_gap < L_MRD); w_timing_code = E_TMRD; end
      default: begin w_timing_bad = 1'b0;            w_timing_code = 3'd0;   end
    endcase

    case (w_eff_state)
      M_PWR: begin
        if (!w_is_nop) begin
          w_err_set  = 1'b1;
          w_err_code = E_PWR;
        end
      end
      M_PRE, M_TRP, M_TRFC, M_TMRD: begin
        if (!w_is_nop) begin
          if (w_is_pre && !mon_addr[10]) begin
            w_err_set  = 1'b1;
            w_err_code = E_PREB;
          end else if (w_is_mrs && w_mode_bad) begin
            w_err_set  = 1'b1;
            w_err_code = E_MODE;
          end else if (w_timing_bad) begin
            w_err_set  = 1'b1;
            w_err_code = w_timing_code;
          end else begin
            case (w_eff_state)
              M_PRE: begin
                if (w_is_pre) begin
                  w_state_next = M_TRP;
                end else begin
                  w_err_set  = 1'b1;
                  w_err_code = E_SEQ;
                end
              end
              M_TRP: begin
                if (w_is_ar) begin
                  w_ar_inc     = 1'b1;
                  w_state_next = M_TRFC;
                end else begin
                  w_err_set  = 1'b1;
                  w_err_code = E_SEQ;
                end
              end
              M_TRFC: begin
                if (w_is_ar && (r_ar_cnt < L_AR)) begin
                  w_ar_inc = 1'b1;
                end else if (w_is_mrs && (r_ar_cnt == L_AR)) begin
                  w_mode_load = 1'b1;
                  // With tMRD of one cycle the sequence is complete next cycle.
                  if (L_MRD <= L_ONE) begin
                    w_ready_set  = 1'b1;
                    w_state_next = M_DONE;
                  end else begin
                    w_state_next = M_TMRD;
                  end
                end else begin
                  w_err_set  = 1'b1;
                  w_err_code = E_SEQ;
                end
              end
              default: begin
                // A command in M_TMRD with tMRD already met completes the sequence.
                w_ready_set  = 1'b1;
                w_state_next = M_DONE;
              end
            endcase
          end
        end else if (w_eff_state == M_TMRD && w_gap_next >= L_MRD) begin
          // Ready is registered so that it is high in the cycle where gap = tMRD.
          w_ready_set  = 1'b1;
          w_state_next = M_DONE;
        end
      end
      default: begin
        // M_DONE and M_ERR are absorbing: the bus is ignored.
      end
    endcase

    if (w_err_set) begin
      w_state_next = M_ERR;
    end
  end

  // State, counters and captured results; all cleared by the async reset.
  always_ff @(posedge mon_clk or negedge mon_rst_n) begin
    if (!mon_rst_n) begin
      r_state    <= M_PWR;
      r_pwr_cnt  <= '0;
      r_gap      <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_mode     <= 13'd0;
      r_ar_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
      if (r_pwr_cnt != {PWR_W{1'b1}}) begin
        r_pwr_cnt <= r_pwr_cnt + 1'b1;
      end
      if (w_err_set && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
      if (w_ar_inc && (r_ar_cnt < L_AR)) begin
        r_ar_cnt <= r_ar_cnt + 4'd1;
      end
      if (w_mode_load) begin
        r_mode <= mon_addr;
      end
      if (w_ready_set) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign mon_ready    = r_ready;
  assign mon_err      = r_err;
  assign mon_err_code = r_err_code;
  assign mon_mode     = r_mode;
  assign mon_ar_cnt   = r_ar_cnt;

endmodule
